instr_fifo: RTL and testbench

INSTR_FIFO -- requirements
Module: instr_fifo

---
 rtl/instr_fifo.sv | 135 +++++++++++++
 tb/tb_instr_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fifo.sv
// Instruction FIFO: three independent lanes (32/32/16 bits) that together
// hold 80-bit instructions. Each lane is pushed on its own, while the consumer
// pops all three lanes together. Reads are first-word-fall-through.

// One storage lane. It has its own pointers and occupancy count.
module instr_fifo_lane #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              lane_empty,
  output logic              lane_full
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push_ok;

  // A full lane can still take a write when a pop frees the head slot in the
  // same cycle. Writes are ignored while reset is held.
  always_comb begin
    lane_empty = (count == '0);
    lane_full  = (count == CNT_W'(FIFO_DEPTH));
    push_ok    = push && !rst && (!lane_full || pop);
    rdata      = mem[rd_ptr];
  end

  // Storage array. It is left out of reset on purpose: the output mask in the
  // top level hides stale contents.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy. The pointers wrap through natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// Top level. It joins the three lanes into one instruction stream.
module instr_fifo #(
  parameter int FIFO_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lower_word,
  input  logic [31:0] middle_word,
  input  logic [15:0] upper_word,
  input  logic [2:0]  write_en,
  input  logic        next_en,
  output logic [79:0] instr_out,
  output logic        empty,
  output logic        full
);

  logic [31:0] lower_q;
  logic [31:0] middle_q;
  logic [15:0] upper_q;
  logic [2:0]  lane_empty;
  logic [2:0]  lane_full;
  logic        pop;

  instr_fifo_lane #(.DATA_W(32), .FIFO_DEPTH(FIFO_DEPTH)) u_lower (
    .clk        (clk),
    .rst        (rst),
    .push       (write_en[0]),
    .pop        (pop),
    .wdata      (lower_word),
    .rdata      (lower_q),
    .lane_empty (lane_empty[0]),
    .lane_full  (lane_full[0])
  );

  instr_fifo_lane #(.DATA_W(32), .FIFO_DEPTH(FIFO_DEPTH)) u_middle (
    .clk        (clk),
    .rst        (rst),
    .push       (write_en[1]),
    .pop        (pop),
    .wdata      (middle_word),
    .rdata      (middle_q),
    .lane_empty (lane_empty[1]),
    .lane_full  (lane_full[1])
  );

  instr_fifo_lane #(.DATA_W(16), .FIFO_DEPTH(FIFO_DEPTH)) u_upper (
    .clk        (clk),
    .rst        (rst),
    .push       (write_en[2]),
    .pop        (pop),
    .wdata      (upper_word),
    .rdata      (upper_q),
    .lane_empty (lane_empty[2]),
    .lane_full  (lane_full[2])
  );

  // An instruction is complete only when every lane holds data. A pop is
  // honoured only then, so no lane can underflow. The head is masked to zero
  // while the FIFO is empty.
  always_comb begin
    empty     = |lane_empty;
    full      = |lane_full;
    pop       = next_en && !empty && !rst;
    instr_out = empty ? '0 : {upper_q, middle_q, lower_q};
  end

endmodule

// File: tb/tb_instr_fifo.sv
// Directed testbench for instr_fifo. Each expected value is written out by hand.
module tb_instr_fifo;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] lower_word = '0;
  logic [31:0] middle_word = '0;
  logic [15:0] upper_word = '0;
  logic [2:0]  write_en = '0;
  logic        next_en = 1'b0;
  logic [79:0] instr_out;
  logic        empty;
  logic        full;

  int errors = 0;
  int checks = 0;

  instr_fifo #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .lower_word  (lower_word),
    .middle_word (middle_word),
    .upper_word  (upper_word),
    .write_en    (write_en),
    .next_en     (next_en),
    .instr_out   (instr_out),
    .empty       (empty),
    .full        (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 ns so the outputs can be sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] mk(input int v);
    logic [15:0] u;
    logic [31:0] m;
    logic [31:0] l;
    u = 16'hC000 | 16'(v);
    m = 32'hB000_0000 | 32'(v);
    l = 32'hA000_0000 | 32'(v);
    return {u, m, l};
  endfunction

  task automatic drive(input int v);
    logic [79:0] w;
    w = mk(v);
    upper_word  = w[79:64];
    middle_word = w[63:32];
    lower_word  = w[31:0];
  endtask

  task automatic idle_checks(input string tag);
    for (int i = 0; i < 5; i++) begin
      step();
      chk({tag, "_empty"}, 80'(empty), 80'(1));
      chk({tag, "_full"},  80'(full),  80'(0));
      chk({tag, "_out"},   instr_out,  80'h0);
    end
  endtask

  task automatic single_push_pop(input string tag);
    lower_word  = 32'h0E00_0000;
    middle_word = 32'h0000_0000;
    upper_word  = 16'h080E;
    write_en    = 3'b111;
    #1;
    chk({tag, "_nobypass"}, 80'(empty), 80'(1));
    step();
    write_en = 3'b000;
    chk({tag, "_empty0"}, 80'(empty), 80'(0));
    chk({tag, "_head"}, instr_out, 80'h080E_00000000_0E000000);
    next_en = 1'b1;
    step();
    next_en = 1'b0;
    chk({tag, "_empty1"}, 80'(empty), 80'(1));
    chk({tag, "_out0"}, instr_out, 80'h0);
  endtask

  initial begin
    // Reset, then stay idle.
    rst = 1'b1;
    step();
    step();
    chk("rst_empty", 80'(empty), 80'(1));
    chk("rst_full",  80'(full),  80'(0));
    chk("rst_out",   instr_out,  80'h0);
    rst = 1'b0;
    idle_checks("idle");

    // Push and pop a single instruction.
    single_push_pop("single");

    // Write the lanes in separate cycles.
    lower_word = 32'h1111_2222; write_en = 3'b001;
    step();
    chk("stag_lower_empty", 80'(empty), 80'(1));
    chk("stag_lower_out", instr_out, 80'h0);
    middle_word = 32'h3333_4444; write_en = 3'b010;
    step();
    chk("stag_middle_empty", 80'(empty), 80'(1));
    upper_word = 16'h5555; write_en = 3'b100;
    #1;
    chk("stag_upper_nobypass", 80'(empty), 80'(1));
    step();
    write_en = 3'b000;
    chk("stag_upper_empty", 80'(empty), 80'(0));
    chk("stag_head", instr_out, 80'h5555_33334444_11112222);
    next_en = 1'b1;
    step();
    next_en = 1'b0;
    chk("stag_drained", 80'(empty), 80'(1));

    // Fill the FIFO, then push once more while it is full.
    for (int i = 0; i < DEPTH; i++) begin
      drive(i);
      write_en = 3'b111;
      step();
      if (i == DEPTH - 2) chk("fill_not_full", 80'(full), 80'(0));
    end
    chk("fill_full", 80'(full), 80'(1));
    drive(77);
    step();
    write_en = 3'b000;
    chk("drop_full", 80'(full), 80'(1));
    chk("drop_head", instr_out, mk(0));
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain_%0d", i), instr_out, mk(i));
      next_en = 1'b1;
      step();
      next_en = 1'b0;
      if (i == 0) chk("drain_full_clr", 80'(full), 80'(0));
    end
    chk("drain_empty", 80'(empty), 80'(1));
    chk("drain_out", instr_out, 80'h0);

    // Push and pop in the same cycle while the FIFO is full.
    for (int i = 0; i < DEPTH; i++) begin
      drive(i);
      write_en = 3'b111;
      step();
    end
    chk("pp_full", 80'(full), 80'(1));
    chk("pp_head0", instr_out, mk(0));
    drive(99);
    write_en = 3'b111;
    next_en  = 1'b1;
    step();
    write_en = 3'b000;
    next_en  = 1'b0;
    chk("pp_still_full", 80'(full), 80'(1));
    chk("pp_head1", instr_out, mk(1));
    for (int i = 1; i <= DEPTH; i++) begin
      chk($sformatf("pp_drain_%0d", i), instr_out, (i == DEPTH) ? mk(99) : mk(i));
      next_en = 1'b1;
      step();
      next_en = 1'b0;
    end
    chk("pp_empty", 80'(empty), 80'(1));

    // Assert reset between clock edges while entries are queued.
    for (int i = 40; i < 50; i++) begin
      drive(i);
      write_en = 3'b111;
      step();
    end
    write_en = 3'b000;
    chk("mid_pre_empty", 80'(empty), 80'(0));
    chk("mid_pre_head", instr_out, mk(40));
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_empty", 80'(empty), 80'(1));
    chk("mid_rst_full",  80'(full),  80'(0));
    chk("mid_rst_out",   instr_out,  80'h0);
    drive(55);
    write_en = 3'b111;
    next_en  = 1'b1;
    step();
    chk("mid_rst_ignore", 80'(empty), 80'(1));
    write_en = 3'b000;
    next_en  = 1'b0;
    #2;
    rst = 1'b0;
    idle_checks("post");
    single_push_pop("post_single");

    // After reset, a push to the lower lane alone must not expose stale data.
    lower_word = 32'hDEAD_BEEF; write_en = 3'b001;
    step();
    write_en = 3'b000;
    chk("post_partial_empty", 80'(empty), 80'(1));
    chk("post_partial_out", instr_out, 80'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
